// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg: shared types, constants and legality checks for dp_ram_sync
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic bit depth_legal(input int depth, input int addr_width);
    return (addr_width >= 1) && (addr_width <= 30) &&
           (depth >= 1) && (depth <= (1 << addr_width));
  endfunction

  function automatic bit latency_legal(input int rd_latency);
    return (rd_latency == 1) || (rd_latency == 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_pipe.sv
// ============================================================================
// ram_rd_pipe: per-port read output register with optional second stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_rd_pipe #(
  parameter int RD_LATENCY = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_vld_q;

  // Data only moves on an accepted read so q holds between reads.
  assign s1_data_d = valid_i ? data_i : s1_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_vld_q  <= valid_i;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_two_stage
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
      logic                  s2_vld_q;

      assign s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          s2_data_q <= '0;
          s2_vld_q  <= 1'b0;
        end else begin
          s2_data_q <= s2_data_d;
          s2_vld_q  <= s1_vld_q;
        end
      end

      assign q_o     = s2_data_q;
      assign valid_o = s2_vld_q;
    end else begin : g_one_stage
      assign q_o     = s1_data_q;
      assign valid_o = s1_vld_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dp_ram_sync.sv
// ============================================================================
// dp_ram_sync: true dual-port synchronous RAM with reset-triggered clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module dp_ram_sync
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    DEPTH          = 256,
  parameter int                    RD_LATENCY     = 1,
  parameter int                    RDW_NEW        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wren_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  valid_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  wren_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  valid_b
);

  generate
    if (!latency_legal(RD_LATENCY)) begin : g_bad_latency
      $error("dp_ram_sync: RD_LATENCY must be 1 or 2");
    end
    if (!depth_legal(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
      $error("dp_ram_sync: DEPTH must be between 1 and 2**ADDR_WIDTH");
    end
    if ((RDW_NEW != RDW_OLD) && (RDW_NEW != ram_pkg::RDW_NEW)) begin : g_bad_rdw
      $error("dp_ram_sync: RDW_NEW must be 0 or 1");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam bit                    c_RDW_NEW   = (RDW_NEW == ram_pkg::RDW_NEW);
  localparam bit                    c_CLEAR_EN  = (CLEAR_ON_RESET != 0);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= c_CLEAR_EN ? CLEAR : READY;
      clr_addr_q <= '0;
      busy_q     <= c_CLEAR_EN;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == c_LAST_ADDR) begin
          state_d    = READY;
          busy_d     = 1'b0;
          clr_addr_d = '0;
        end
      end
      READY:   busy_d = 1'b0;
      default: state_d = READY;
    endcase
  end

  logic w_ready, w_in_a, w_in_b, w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic [DATA_WIDTH-1:0] w_rdata_a, w_rdata_b;

  assign w_ready = reset_n && (state_q == READY);
  assign w_in_a  = ({1'b0, address_a} < c_DEPTH);
  assign w_in_b  = ({1'b0, address_b} < c_DEPTH);
  assign w_wr_a  = w_ready && wren_a && w_in_a;
  assign w_wr_b  = w_ready && wren_b && w_in_b;
  assign w_rd_a  = w_ready && rden_a;
  assign w_rd_b  = w_ready && rden_b;

  // Cross-port reads see the pre-edge array, so they always return old data.
  assign w_rdata_a = !w_in_a                ? '0     :
                     (c_RDW_NEW && wren_a)  ? data_a : mem_q[address_a];
  assign w_rdata_b = !w_in_b                ? '0     :
                     (c_RDW_NEW && wren_b)  ? data_b : mem_q[address_b];

  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state_q == CLEAR) begin
        mem_q[clr_addr_q] <= CLEAR_VALUE;
      end else begin
        if (w_wr_b) mem_q[address_b] <= data_b;
        if (w_wr_a) mem_q[address_a] <= data_a;
      end
    end
  end

  ram_rd_pipe #(
    .RD_LATENCY(RD_LATENCY),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_pipe_a (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .valid_i(w_rd_a),
    .data_i (w_rdata_a),
    .q_o    (q_a),
    .valid_o(valid_a)
  );

  ram_rd_pipe #(
    .RD_LATENCY(RD_LATENCY),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_pipe_b (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .valid_i(w_rd_b),
    .data_i (w_rdata_b),
    .q_o    (q_b),
    .valid_o(valid_b)
  );

  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dp_ram_sync.sv
// ============================================================================
// tb_dp_ram_sync: scoreboard bench driving two differently configured RAMs
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dp_ram_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr_a, addr_b, data_a, data_b;
  logic       wren_a, wren_b, rden_a, rden_b;

  logic [1:0] busy_w;
  logic [3:0] vv;
  logic [7:0] qv [4];

  always #5 clk = ~clk;

  // dut0: full depth, latency 1, old-data RDW; dut1: depth 200, latency 2, new-data RDW
  dp_ram_sync #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .RD_LATENCY(1),
    .RDW_NEW(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)
  ) u_dut0 (
    .clock(clk), .reset_n(rst_n), .busy(busy_w[0]),
    .address_a(addr_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
    .q_a(qv[0]), .valid_a(vv[0]),
    .address_b(addr_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
    .q_b(qv[1]), .valid_b(vv[1])
  );

  dp_ram_sync #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200), .RD_LATENCY(2),
    .RDW_NEW(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)
  ) u_dut1 (
    .clock(clk), .reset_n(rst_n), .busy(busy_w[1]),
    .address_a(addr_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
    .q_a(qv[2]), .valid_a(vv[2]),
    .address_b(addr_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
    .q_b(qv[3]), .valid_b(vv[3])
  );

  typedef struct {
    int         port;
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         clr_left [2];
  int         bcnt [2];
  logic [7:0] mdl [2][256];

  function automatic int dep(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [7:0] rd_val(input int d, input logic [7:0] a,
                                        input logic [7:0] wd, input logic we);
    if (int'(a) >= dep(d)) return 8'h00;
    if (d == 1 && we) return wd;
    return mdl[d][a];
  endfunction

  // Reference behaviour for one rising edge, applied to both RAM configurations.
  task automatic model_edge();
    if (!rst_n) expq.delete();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        clr_left[d] = dep(d);
      end else if (clr_left[d] > 0) begin
        clr_left[d]--;
        if (clr_left[d] == 0)
          for (int i = 0; i < dep(d); i++) mdl[d][i] = 8'hA5;
      end else begin
        if (rden_a) expq.push_back('{port: d*2,   cyc: cyc + lat(d) - 1,
                                     data: rd_val(d, addr_a, data_a, wren_a)});
        if (rden_b) expq.push_back('{port: d*2+1, cyc: cyc + lat(d) - 1,
                                     data: rd_val(d, addr_b, data_b, wren_b)});
        if (wren_b && int'(addr_b) < dep(d)) mdl[d][addr_b] = data_b;
        if (wren_a && int'(addr_a) < dep(d)) mdl[d][addr_a] = data_a;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (busy_w[d] !== (clr_left[d] != 0)) begin
        n_fail++;
        $display("FAIL busy_dut%0d cyc=%0d: got %0b expected %0b",
                 d, cyc, busy_w[d], (clr_left[d] != 0));
      end
      if (busy_w[d] === 1'b1) bcnt[d]++;
    end
  endtask

  task automatic idle();
    wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
  endtask

  task automatic reset_seq(input int n);
    idle();
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [7:0] d);
    idle(); wren_a = 1'b1; addr_a = a; data_a = d; step();
  endtask

  // Monitor: each presented valid must match the oldest outstanding read for that port.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      int idx;
      idx = -1;
      for (int i = 0; i < expq.size(); i++)
        if (expq[i].port == p) begin idx = i; break; end
      if (idx >= 0 && expq[idx].cyc <= cyc) begin
        n_checks++;
        if (vv[p] !== 1'b1 || expq[idx].cyc != cyc) begin
          n_fail++;
          $display("FAIL rd_valid port%0d cyc=%0d: got valid=%0b expected valid at cyc %0d",
                   p, cyc, vv[p], expq[idx].cyc);
        end else if (qv[p] !== expq[idx].data) begin
          n_fail++;
          $display("FAIL rd_data port%0d cyc=%0d: got %0h expected %0h",
                   p, cyc, qv[p], expq[idx].data);
        end
        expq.delete(idx);
      end else if (vv[p] === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected port%0d cyc=%0d: got valid=1 expected valid=0", p, cyc);
      end
    end
  end

  initial begin
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    reset_seq(3);
    for (int p = 0; p < 4; p++) begin
      check_val("reset_q", 32'(qv[p]), 32'h0);
      check_val("reset_valid", 32'(vv[p]), 32'h0);
    end
    check_val("reset_busy", 32'(busy_w), 32'h3);

    // Initial clear
    bcnt[0] = 1; bcnt[1] = 1;
    repeat (260) step();
    check_val("clear_busy_cycles_d0", 32'(bcnt[0]), 32'd256);
    check_val("clear_busy_cycles_d1", 32'(bcnt[1]), 32'd200);

    idle(); rden_a = 1'b1; addr_a = 8'd0;   rden_b = 1'b1; addr_b = 8'd127; step();
    idle(); rden_a = 1'b1; addr_a = 8'd255; step();
    idle(); step(); step();

    // Same-port read-during-write, then follow-up read
    wr_a(8'd10, 8'h11);
    idle(); wren_a = 1'b1; rden_a = 1'b1; addr_a = 8'd10; data_a = 8'h3C; step();
    idle(); rden_a = 1'b1; addr_a = 8'd10; step();

    // Dual-write collision; B reads back the winner
    idle(); wren_a = 1'b1; addr_a = 8'd40; data_a = 8'h01;
    wren_b = 1'b1; addr_b = 8'd40; data_b = 8'h02; step();
    idle(); rden_b = 1'b1; addr_b = 8'd40; step();

    // Back-to-back burst, pipelined reads
    for (int i = 0; i < 8; i++) wr_a(8'(i), 8'(i * 3));
    for (int i = 0; i < 8; i++) begin
      idle(); rden_a = 1'b1; addr_a = 8'(i); step();
    end
    idle(); step(); step();

    // Out-of-range on the 200-deep instance
    wr_a(8'd199, 8'h77);
    wr_a(8'd210, 8'hFF);
    idle(); rden_a = 1'b1; addr_a = 8'd210; rden_b = 1'b1; addr_b = 8'd199; step();
    idle(); step(); step();

    // Random dual-port traffic
    for (int i = 0; i < 400; i++) begin
      addr_a = 8'($urandom_range(0, 255)); data_a = 8'($urandom);
      addr_b = 8'($urandom_range(0, 255)); data_b = 8'($urandom);
      wren_a = 1'($urandom); rden_a = 1'($urandom);
      wren_b = 1'($urandom); rden_b = 1'($urandom);
      step();
    end

    // Read in flight when reset asserts, then reset again mid-clear
    idle(); rden_a = 1'b1; rden_b = 1'b1; addr_a = 8'd3; addr_b = 8'd4; step();
    reset_seq(2);
    repeat (100) step();
    reset_seq(2);
    bcnt[0] = 1; bcnt[1] = 1;
    for (int i = 0; i < 300; i++) begin
      idle();
      if (i < 50) begin
        wren_a = 1'b1; addr_a = 8'(i); data_a = 8'h5A;
        wren_b = 1'b1; addr_b = 8'(i + 100); data_b = 8'h3D;
        rden_a = 1'b1; rden_b = 1'b1;
      end
      step();
    end
    check_val("reclear_busy_cycles_d0", 32'(bcnt[0]), 32'd256);
    check_val("reclear_busy_cycles_d1", 32'(bcnt[1]), 32'd200);

    // Full readback after clear
    for (int i = 0; i < 256; i++) begin
      idle(); rden_a = 1'b1; addr_a = 8'(i); rden_b = 1'b1; addr_b = 8'(255 - i); step();
    end
    idle();
    repeat (4) step();
    check_val("scoreboard_drained", 32'(expq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dp_ram_sync.md
# dp_ram_sync

Parametrised true dual-port synchronous RAM, the successor to the single-port simulation RAM/ROM models used by the decryption datapath. It adds:
- a second independent port;
- selectable read latency and read-during-write behaviour;
- per-port read-valid tracking;
- a reset-triggered clear sequencer that writes a known value to every location.

It sits between the key-schedule/decrypt FSMs and their working memories, both in simulation and as synthesisable RTL.

## Interface
- ADDR_WIDTH, 8, address bits per port
- DATA_WIDTH, 8, word width
- DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
- RDW_NEW, 0, same-port read-during-write: 0 returns old data, 1 returns the new (written) data
- CLEAR_ON_RESET, 1, 1 runs the clear sequence after reset; 0 skips it
- CLEAR_VALUE, 0, word written to every location during clear

Ports (clock and reset first):
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- busy  out  1  high while clearing; user accesses ignored
- address_a  in  ADDR_WIDTH  port A address
- data_a  in  DATA_WIDTH  port A write data
- wren_a  in  1  port A write enable
- rden_a  in  1  port A read enable
- q_a  out  DATA_WIDTH  port A read data
- valid_a  out  1  q_a holds data for an accepted read
- address_b, data_b, wren_b, rden_b, q_b, valid_b: identical for port B

## Operation
- Controller states: CLEAR, READY.
- While reset_n = 0 at an edge:
  - state <= CLEAR, or READY when CLEAR_ON_RESET = 0;
  - clr_addr <= 0;
  - busy <= CLEAR_ON_RESET;
  - q_a, q_b, valid_a, valid_b and all pipeline stages <= 0.
- Memory contents are not touched by reset itself.
- CLEAR:
  - each edge writes CLEAR_VALUE to mem[clr_addr], then clr_addr increments;
  - at clr_addr = DEPTH-1: state <= READY, busy <= 0.
  - All user wren/rden are ignored; valid stays 0.
- Reset asserted mid-clear restarts the sequence at address 0.
- READY, write:
  - wren_x at an edge writes data_x to mem[address_x].
  - If both ports write the same address in the same cycle, port A wins.
- READY, read:
  - rden_x at an edge captures mem[address_x].
  - Same-port write in the same cycle: result follows RDW_NEW.
  - Cross-port read of an address being written by the other port always returns the old data.
- Out of range (address_x >= DEPTH): write dropped; read returns 0 with valid asserted normally.
- With rden_x = 0, q_x holds its last value; valid_x = 0.

## Timing
- Read issued (rden_x = 1) at edge N:
  - q_x/valid_x update at edge N + RD_LATENCY - 1, so RD_LATENCY = 1 means visible immediately after edge N;
  - valid_x is high for exactly one cycle per accepted read.
- Back-to-back reads are fully pipelined: one result per cycle on each port, no bubbles.
- Write at edge N is readable by a read issued at edge N+1 on either port.
- Clear timing:
  - reset_n is released before edge E0;
  - edges E0..E(DEPTH-1) clear addresses 0..DEPTH-1;
  - busy = 0 after E(DEPTH-1);
  - the first user access is accepted at E(DEPTH).
- CLEAR_ON_RESET = 0: busy is 0 from the first reset edge; a user access is accepted at E0.
- Pipeline contents on reset: a read in flight in the RD_LATENCY = 2 pipeline when reset asserts is discarded (valid never rises).

## Structure
- Package ram_pkg:
  - clear-state enum (CLEAR, READY);
  - RDW_OLD/RDW_NEW constants;
  - function checking DEPTH/ADDR_WIDTH legality.
- Elaboration-time error on an illegal RD_LATENCY or DEPTH.
- One sub-module, ram_rd_pipe: per-port output register plus optional second stage carrying q and valid. It is instantiated twice, parametrised by RD_LATENCY and DATA_WIDTH, with synchronous active-low clear.
- Memory array and clear controller live in dp_ram_sync.

## Test plan
- Clear:
  - defaults, CLEAR_VALUE = 8'hA5; reset 3 cycles, release;
  - expect busy high exactly 256 cycles;
  - reads of addresses 0, 127, 255 then return 8'hA5 with valid one cycle after rden.
- Same-port read-during-write:
  - port A writes 8'h3C to addr 10 (holding 8'h11) with rden_a = 1;
  - expect q_a = 8'h11 for RDW_NEW = 0 and 8'h3C for RDW_NEW = 1;
  - a following read returns 8'h3C.
- Dual-write collision:
  - A writes 8'h01 and B writes 8'h02 to addr 40 in the same cycle;
  - a subsequent read on B returns 8'h01.
- Latency 2:
  - RD_LATENCY = 2; reads of addresses 0..7 (holding i*3) issued on consecutive cycles;
  - expect valid_a high for 8 consecutive cycles starting 2 edges after the first rden;
  - data 0, 3, 6 … 21 in order.
- Reset mid-clear:
  - assert reset_n = 0 at clear cycle 100; release;
  - expect busy high a full 256 cycles again and every location equal to CLEAR_VALUE;
  - user write attempted during busy has no effect.
- Out of range:
  - DEPTH = 200; write 8'hFF to addr 210, read addr 210;
  - expect q = 0 with valid = 1; addr 199 is unaffected.
